component_stream_merger: RTL and testbench

- Parametrised successor to the per-component bitstream OR-combiner.
- Accepts NUM_CH independent component bit-fragment streams (Y, Cb, Cr, optional alpha), each tagged {val, size_of_bit, flush}, and buffers each in its own FIFO.
- Drains the FIFOs strictly in channel order 0..NUM_CH-1 into one set-bit stream with valid/ready backpressure.
- Lets component encoders run concurrently instead of serially; sits between the component encoders and the slice bit packer.

---
 rtl/component_stream_merger.sv | 161 ++++++++++++++++
 tb/tb_component_stream_merger.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/component_stream_merger.sv
`default_nettype none
// component_stream_merger: per-channel fragment FIFOs drained strictly in channel order into one stream.
// Optional build macro COMPONENT_STREAM_MERGER_BITCOUNT_EN adds the 32-bit slice bit counter.
module component_stream_merger #(
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 64,
  parameter int VAL_W      = 64,
  parameter int SIZE_W     = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        in_enable,
  input  logic [NUM_CH*VAL_W-1:0]  in_val,
  input  logic [NUM_CH*SIZE_W-1:0] in_size_of_bit,
  input  logic [NUM_CH-1:0]        in_flush,
  output logic [NUM_CH-1:0]        ch_full,
  output logic [NUM_CH-1:0]        ch_overflow,
  output logic                     sb_enable,
  output logic [VAL_W-1:0]         sb_val,
  output logic [SIZE_W-1:0]        sb_size_of_bit,
  output logic                     sb_flush,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     slice_done,
  output logic [31:0]              slice_bit_count
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ENTRY_W = 1 + SIZE_W + VAL_W;
  localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [CH_W-1:0]    cur_ch;
  logic [NUM_CH-1:0]  empty, pop;
  logic [ENTRY_W-1:0] head [NUM_CH];
  logic [ENTRY_W-1:0] cur_head;
  logic               load, accept, do_pop, head_flush;

  assign load       = !sb_enable || out_ready;
  assign accept     = sb_enable && out_ready;
  assign cur_head   = head[cur_ch];
  assign head_flush = cur_head[ENTRY_W-1];
  // A held final fragment blocks further pops until it is accepted.
  assign do_pop     = (state == S_DRAIN) && load && !sb_flush && !empty[cur_ch];

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_fifo
      logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]      rd_ptr, wr_ptr;
      logic [AW:0]        count, count_nxt;
      logic               push, full_r, ovf_r;

      assign pop[g]       = do_pop && (cur_ch == CH_W'(g));
      assign push         = in_enable[g] && ((count != DEPTH_CNT) || pop[g]);
      assign empty[g]     = (count == '0);
      assign head[g]      = mem[rd_ptr];
      assign count_nxt    = count + (AW+1)'(push) - (AW+1)'(pop[g]);
      assign ch_full[g]   = full_r;
      assign ch_overflow[g] = ovf_r;

      always_ff @(posedge clock) begin
        if (push) begin
          mem[wr_ptr] <= {in_flush[g], in_size_of_bit[g*SIZE_W +: SIZE_W], in_val[g*VAL_W +: VAL_W]};
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
          full_r <= 1'b0;
          ovf_r  <= 1'b0;
        end else begin
          if (push)   wr_ptr <= wr_ptr + AW'(1);
          if (pop[g]) rd_ptr <= rd_ptr + AW'(1);
          count  <= count_nxt;
          full_r <= (count_nxt == DEPTH_CNT);
          ovf_r  <= ovf_r | (in_enable[g] & ~push);
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRAIN;
      S_DRAIN: if (accept && sb_flush) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    slice_done = (state == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_ch <= '0;
    end else if ((state == S_DONE) || ((state == S_IDLE) && start)) begin
      cur_ch <= '0;
    end else if (do_pop && head_flush && (cur_ch != LAST_CH)) begin
      cur_ch <= cur_ch + CH_W'(1);
    end
  end

  // Flush markers of non-final channels only advance cur_ch; they are not forwarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_enable      <= 1'b0;
      sb_val         <= '0;
      sb_size_of_bit <= '0;
      sb_flush       <= 1'b0;
    end else if ((state == S_DRAIN) && load) begin
      if (do_pop) begin
        sb_enable      <= 1'b1;
        sb_val         <= cur_head[VAL_W-1:0];
        sb_size_of_bit <= cur_head[VAL_W +: SIZE_W];
        sb_flush       <= head_flush && (cur_ch == LAST_CH);
      end else begin
        sb_enable <= 1'b0;
        sb_flush  <= 1'b0;
      end
    end
  end

`ifdef COMPONENT_STREAM_MERGER_BITCOUNT_EN
  logic [31:0] bit_acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_acc <= '0;
    end else if ((state == S_IDLE) && start) begin
      bit_acc <= '0;
    end else if (accept) begin
      bit_acc <= bit_acc + 32'(sb_size_of_bit);
    end
  end

  assign slice_bit_count = bit_acc;
`else
  assign slice_bit_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_component_stream_merger.sv
`default_nettype none
// Randomized self-checking bench for component_stream_merger against a queue-based reference model.
module tb_component_stream_merger;
  localparam int NCH = 3, DEPTH = 4, VW = 64, SW = 64;

  logic              clock = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [NCH-1:0]    in_enable = '0, in_flush = '0;
  logic [NCH*VW-1:0] in_val = '0;
  logic [NCH*SW-1:0] in_size_of_bit = '0;
  logic [NCH-1:0]    ch_full, ch_overflow;
  logic              sb_enable, sb_flush, busy, slice_done;
  logic [VW-1:0]     sb_val;
  logic [SW-1:0]     sb_size_of_bit;
  logic [31:0]       slice_bit_count;

  typedef struct {
    logic [63:0] v;
    logic [63:0] s;
    logic        f;
  } frag_t;

  frag_t          mq[NCH][$];
  frag_t          got[$];
  frag_t          exp_q[$];
  logic [NCH-1:0] exp_ovf = '0;
  int             tests = 0, fails = 0;
  int             rdy_mode = 0;

  always #5 clock = ~clock;

  component_stream_merger #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .VAL_W(VW), .SIZE_W(SW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_enable(in_enable), .in_val(in_val), .in_size_of_bit(in_size_of_bit), .in_flush(in_flush),
    .ch_full(ch_full), .ch_overflow(ch_overflow),
    .sb_enable(sb_enable), .sb_val(sb_val), .sb_size_of_bit(sb_size_of_bit), .sb_flush(sb_flush),
    .out_ready(out_ready), .busy(busy), .slice_done(slice_done), .slice_bit_count(slice_bit_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Stage one write for the next edge and update the model (FIFO idle: no concurrent pop).
  task automatic wr(input int ch, input logic [63:0] v, input logic [63:0] s, input logic f);
    frag_t e;
    in_enable[ch] = 1'b1;
    in_val[ch*VW +: VW] = v;
    in_size_of_bit[ch*SW +: SW] = s;
    in_flush[ch] = f;
    e.v = v; e.s = s; e.f = f;
    if (mq[ch].size() < DEPTH) mq[ch].push_back(e);
    else exp_ovf[ch] = 1'b1;
  endtask

  task automatic wr1(input int ch, input logic [63:0] v, input logic [63:0] s, input logic f);
    wr(ch, v, s, f);
    cyc();
    in_enable = '0;
  endtask

  function automatic logic [63:0] rsize();
    case ($urandom_range(0, 3))
      0:       return 64'd0;
      1:       return 64'($urandom_range(1, 64));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Expected slice: each channel in order up to and including its flush; only the last channel's flush is forwarded.
  task automatic build_exp();
    frag_t e;
    bit    done;
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin
      done = 1'b0;
      while (!done && mq[c].size() > 0) begin
        e = mq[c].pop_front();
        done = e.f;
        e.f = e.f && (c == NCH - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_slice(input bit do_start, input bit speed, input bit stall, input bit inj, input frag_t inj_e);
    int          k;
    bit          seen;
    logic [31:0] sum;
    build_exp();
    if (do_start) begin
      got.delete();
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("bit_count_clear", 64'(slice_bit_count), 64'd0);
    end
    k = 1;
    check("busy_drain", 64'(busy), 64'd1);
    if (inj) begin
      in_enable[0] = 1'b1;
      in_val[VW-1:0] = inj_e.v;
      in_size_of_bit[SW-1:0] = inj_e.s;
      in_flush[0] = inj_e.f;
    end
    seen = 1'b0;
    while (!seen && k < 300) begin
      @(negedge clock);
      if (slice_done) seen = 1'b1;
      else begin
        cyc();
        k++;
        if (inj && k == 2) in_enable = '0;
        if (stall && k == 3) rdy_mode = 2;
        if (stall && k == 9) rdy_mode = 0;
      end
    end
    check("slice_done_seen", 64'(seen), 64'd1);
    if (speed) check("slice_cycles", 64'(k), 64'(exp_q.size() + 2));
    sum = '0;
    foreach (exp_q[i]) sum += exp_q[i].s[31:0];
`ifdef COMPONENT_STREAM_MERGER_BITCOUNT_EN
    check("bit_count", 64'(slice_bit_count), 64'(sum));
`else
    check("bit_count", 64'(slice_bit_count), 64'd0);
`endif
    check("frag_count", 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check("frag_val", got[i].v, exp_q[i].v);
      check("frag_size", got[i].s, exp_q[i].s);
      check("frag_flush", 64'(got[i].f), 64'(exp_q[i].f));
    end
    cyc();
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: records accepted fragments and checks hold-under-backpressure.
  initial begin : mon
    logic        pst, pf;
    logic [63:0] pv, ps;
    frag_t       e;
    pst = 1'b0; pf = 1'b0; pv = '0; ps = '0;
    forever begin
      @(negedge clock);
      if (reset) pst = 1'b0;
      else begin
        if (pst) begin
          check("hold_en", 64'(sb_enable), 64'd1);
          check("hold_val", sb_val, pv);
          check("hold_size", sb_size_of_bit, ps);
          check("hold_flush", 64'(sb_flush), 64'(pf));
        end
        if (sb_enable && out_ready) begin
          e.v = sb_val; e.s = sb_size_of_bit; e.f = sb_flush;
          got.push_back(e);
        end
        pst = sb_enable && !out_ready;
        pv = sb_val; ps = sb_size_of_bit; pf = sb_flush;
      end
    end
  end

  initial begin
    frag_t none, e;
    int    n[NCH], sent[NCH];
    bit    any;
    none.v = '0; none.s = '0; none.f = 1'b0;

    cyc(); cyc();
    check("rst_sb_enable", 64'(sb_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_full", 64'(ch_full), 64'd0);
    check("rst_bit_count", 64'(slice_bit_count), 64'd0);
    reset = 1'b0;
    cyc();

    // Directed slice with mid-channel flushes not forwarded
    wr1(0, 64'h5, 64'd3, 1'b0);
    wr1(0, 64'h1, 64'd1, 1'b1);
    wr1(1, 64'h3, 64'd2, 1'b1);
    wr1(2, 64'hF, 64'd4, 1'b1);
    run_slice(1'b1, 1'b1, 1'b0, 1'b0, none);

    // Out-of-order arrival
    wr1(2, 64'h22, 64'd7, 1'b1);
    wr1(1, 64'h11, 64'd5, 1'b1);
    wr(0, 64'h0A, 64'd1, 1'b0); wr(2, 64'h2B, 64'd2, 1'b0); cyc(); in_enable = '0;
    wr1(0, 64'h0B, 64'd9, 1'b1);
    run_slice(1'b1, 1'b0, 1'b0, 1'b0, none);
    // The 0x2B entry came after ch2's flush, so it leads the next slice.
    wr1(0, 64'h30, 64'd1, 1'b1);
    wr1(1, 64'h31, 64'd1, 1'b1);
    wr1(2, 64'h32, 64'd1, 1'b1);
    run_slice(1'b1, 1'b0, 1'b0, 1'b0, none);

    // Backpressure mid-slice
    for (int i = 0; i < 3; i++) wr1(0, 64'h100 + 64'(i), 64'(i + 1), i == 2);
    wr1(1, 64'h200, 64'd6, 1'b0);
    wr1(1, 64'h201, 64'd7, 1'b1);
    wr1(2, 64'h300, 64'd8, 1'b0);
    wr1(2, 64'h301, 64'd9, 1'b1);
    run_slice(1'b1, 1'b0, 1'b1, 1'b0, none);

    // Full and overflow on ch1
    for (int i = 0; i < 5; i++) begin
      wr1(1, 64'h40 + 64'(i), 64'(i), i == 3);
      if (i == 2) check("full_after3", 64'(ch_full[1]), 64'd0);
      if (i == 3) check("full_after4", 64'(ch_full[1]), 64'd1);
      if (i == 3) check("ovf_after4", 64'(ch_overflow[1]), 64'd0);
    end
    check("ovf_after5", 64'(ch_overflow), 64'(exp_ovf));
    wr(0, 64'h50, 64'd1, 1'b1); wr(2, 64'h52, 64'd1, 1'b1); cyc(); in_enable = '0;
    run_slice(1'b1, 1'b1, 1'b0, 1'b0, none);

    // Write into a full FIFO in the same cycle as its pop
    for (int i = 0; i < 4; i++) wr1(0, 64'h60 + 64'(i), 64'd2, 1'b0);
    check("full_ch0", 64'(ch_full[0]), 64'd1);
    wr(1, 64'h71, 64'd3, 1'b1); wr(2, 64'h72, 64'd3, 1'b1); cyc(); in_enable = '0;
    e.v = 64'h6F; e.s = 64'd5; e.f = 1'b1;
    mq[0].push_back(e);
    run_slice(1'b1, 1'b1, 1'b0, 1'b1, e);
    check("ovf_concurrent", 64'(ch_overflow), 64'(exp_ovf));

    // Reset mid-drain
    for (int i = 0; i < 3; i++) wr1(0, 64'h80 + 64'(i), 64'd1, i == 2);
    wr1(1, 64'h90, 64'd1, 1'b1);
    wr1(2, 64'hA0, 64'd1, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    check("mrst_sb_enable", 64'(sb_enable), 64'd0);
    check("mrst_sb_val", sb_val, 64'd0);
    check("mrst_sb_size", sb_size_of_bit, 64'd0);
    check("mrst_sb_flush", 64'(sb_flush), 64'd0);
    check("mrst_full", 64'(ch_full), 64'd0);
    check("mrst_ovf", 64'(ch_overflow), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(slice_done), 64'd0);
    check("mrst_bit_count", 64'(slice_bit_count), 64'd0);
    for (int c = 0; c < NCH; c++) mq[c].delete();
    exp_ovf = '0;
    got.delete();
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    check("empty_after_rst", 64'(sb_enable), 64'd0);

    // Write-to-output latency while already draining
    wr(0, 64'hAB, 64'd8, 1'b1); cyc(); in_enable = '0;
    check("lat_t1", 64'(sb_enable), 64'd0);
    cyc();
    check("lat_t2", 64'(sb_enable), 64'd1);
    check("lat_val", sb_val, 64'hAB);
    wr(1, 64'hAC, 64'd2, 1'b1); wr(2, 64'hAD, 64'd3, 1'b1); cyc(); in_enable = '0;
    run_slice(1'b0, 1'b0, 1'b0, 1'b0, none);

    // Back-to-back slices, second start in the cycle after slice_done
    for (int c = 0; c < NCH; c++) begin
      wr1(c, 64'hB0 + 64'(c), 64'(c + 1), 1'b1);
      wr1(c, 64'hC0 + 64'(c), 64'(c + 10), 1'b1);
    end
    run_slice(1'b1, 1'b1, 1'b0, 1'b0, none);
    run_slice(1'b1, 1'b1, 1'b0, 1'b0, none);

    // Randomized slices with concurrent per-channel writes and random backpressure
    for (int sl = 0; sl < 12; sl++) begin
      for (int c = 0; c < NCH; c++) begin
        n[c] = $urandom_range(1, DEPTH);
        sent[c] = 0;
      end
      any = 1'b1;
      while (any) begin
        any = 1'b0;
        for (int c = 0; c < NCH; c++)
          if (sent[c] < n[c] && $urandom_range(0, 1) == 1) begin
            wr(c, {$urandom, $urandom}, rsize(), sent[c] == n[c] - 1);
            sent[c]++;
          end
        cyc();
        in_enable = '0;
        for (int c = 0; c < NCH; c++) if (sent[c] < n[c]) any = 1'b1;
      end
      for (int c = 0; c < NCH; c++)
        if (mq[c].size() == DEPTH && $urandom_range(0, 1) == 1) wr1(c, {$urandom, $urandom}, 64'd1, 1'b0);
      for (int c = 0; c < NCH; c++) check("rand_full", 64'(ch_full[c]), 64'(mq[c].size() == DEPTH));
      check("rand_ovf", 64'(ch_overflow), 64'(exp_ovf));
      rdy_mode = 1;
      run_slice(1'b1, 1'b0, 1'b0, 1'b0, none);
      rdy_mode = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
